// File: rtl/psram_async_ctrl.sv
// psram_async_ctrl
//   Sequences one word access at a time to an external cellular RAM running in
//   asynchronous mode. A request accepted from the audio datapath becomes a
//   SETUP / ACCESS / HOLD / RECOVER pattern on the active-low CE#, OE# and WE#
//   pins. Read data returns with a one-cycle rd_valid pulse.
//
//   The pin strobes, ready, busy and read data are all registered. Each is
//   decoded from the next state, so the pin pattern lines up with the state
//   that the FSM occupies during the same cycle.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (accepted when both high)
//   req_we/req_addr/req_wdata request direction, word address, write data
//   rd_valid/rd_data         read-return pulse and held read word
//   busy                     controller is not idle
//   mem_addr, mem_dq_o       registered address / write data to the pins
//   mem_dq_oe, mem_dq_i      DQ tristate enable and DQ input
//   mem_ce_n/oe_n/we_n       active-low strobes
//   mem_adv_n/ub_n/lb_n/cre  tied low (asynchronous mode, full-word access)
module psram_async_ctrl #(
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 16,
  parameter int RD_CYC  = 7,
  parameter int WR_CYC  = 7,
  parameter int REC_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dq_o,
  output logic              mem_dq_oe,
  input  logic [DATA_W-1:0] mem_dq_i,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic              mem_adv_n,
  output logic              mem_ub_n,
  output logic              mem_lb_n,
  output logic              mem_cre
);

  localparam int MAX_RW  = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
  localparam int MAX_CYC = (MAX_RW > REC_CYC) ? MAX_RW : REC_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Counter is loaded with (length - 1) on state entry and the state is left
  // when it reaches zero.
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WR_CYC - 1);
  localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'((REC_CYC > 0) ? (REC_CYC - 1) : 0);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] wait_cnt_r;
  logic             we_r;
  logic             accept_s;
  logic             op_we_s;

  // CE# is low for the whole SETUP..HOLD window.
  function automatic logic ce_window(input state_t s);
    return (s == ST_SETUP) || (s == ST_ACCESS) || (s == ST_HOLD);
  endfunction

  // Handshake and effective direction. In IDLE the latch has not been loaded
  // yet, so the strobes registered at the accept edge take the live req_we.
  always_comb begin
    accept_s = req_valid & req_ready;
    if (state_r == ST_IDLE) begin
      op_we_s = req_we;
    end else begin
      op_we_s = we_r;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_state_s = ST_SETUP;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SETUP: next_state_s = ST_ACCESS;
      ST_ACCESS: begin
        if (wait_cnt_r == CNT_ZERO) begin
          next_state_s = ST_HOLD;
        end else begin
          next_state_s = ST_ACCESS;
        end
      end
      ST_HOLD: begin
        if (REC_CYC == 0) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        if (wait_cnt_r == CNT_ZERO) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_RECOVER;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Wait counter: loaded on entry to ACCESS or RECOVER, counts down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= CNT_ZERO;
    end else if ((state_r != ST_ACCESS) && (next_state_s == ST_ACCESS)) begin
      wait_cnt_r <= op_we_s ? WR_LOAD : RD_LOAD;
    end else if ((state_r != ST_RECOVER) && (next_state_s == ST_RECOVER)) begin
      wait_cnt_r <= REC_LOAD;
    end else if (wait_cnt_r != CNT_ZERO) begin
      wait_cnt_r <= wait_cnt_r - CNT_ONE;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Request latch: captured only at accept, untouched until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_r     <= 1'b0;
      mem_addr <= {ADDR_W{1'b0}};
      mem_dq_o <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      we_r     <= req_we;
      mem_addr <= req_addr;
      mem_dq_o <= req_wdata;
    end else begin
      we_r     <= we_r;
      mem_addr <= mem_addr;
      mem_dq_o <= mem_dq_o;
    end
  end

  // Registered pin strobes and status, decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_ce_n  <= 1'b1;
      mem_oe_n  <= 1'b1;
      mem_we_n  <= 1'b1;
      mem_dq_oe <= 1'b0;
      rd_valid  <= 1'b0;
      req_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mem_ce_n  <= ~ce_window(next_state_s);
      mem_oe_n  <= ~((next_state_s == ST_ACCESS) & ~op_we_s);
      mem_we_n  <= ~((next_state_s == ST_ACCESS) & op_we_s);
      mem_dq_oe <= ce_window(next_state_s) & op_we_s;
      rd_valid  <= (next_state_s == ST_HOLD) & ~op_we_s;
      req_ready <= (next_state_s == ST_IDLE);
      busy      <= (next_state_s != ST_IDLE);
    end
  end

  // Read data: DQ is sampled on the edge that closes the last OE# low cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= {DATA_W{1'b0}};
    end else if ((state_r == ST_ACCESS) && (next_state_s == ST_HOLD) && !we_r) begin
      rd_data <= mem_dq_i;
    end else begin
      rd_data <= rd_data;
    end
  end

  assign mem_adv_n = 1'b0;
  assign mem_ub_n  = 1'b0;
  assign mem_lb_n  = 1'b0;
  assign mem_cre   = 1'b0;

endmodule
